// File: rtl/vga_timing_pkg.sv
// Mode constants for the VGA path (800x600 @ 60 Hz, 40 MHz pixel clock).
// Shared by the timing generator and the drawing stages.
package vga_timing_pkg;

   localparam int MODE_H_VISIBLE = 800;
   localparam int MODE_H_FPORCH  = 40;
   localparam int MODE_H_SYNC    = 128;
   localparam int MODE_H_BPORCH  = 88;
   localparam int MODE_V_VISIBLE = 600;
   localparam int MODE_V_FPORCH  = 1;
   localparam int MODE_V_SYNC    = 4;
   localparam int MODE_V_BPORCH  = 23;
   localparam bit MODE_SYNC_POL  = 1'b1;
   localparam int MODE_CW        = 11;

   function automatic int axis_total(input int visible, input int fporch,
                                     input int sync, input int bporch);
      return visible + fporch + sync + bporch;
   endfunction

   localparam int MODE_H_TOTAL = axis_total(MODE_H_VISIBLE, MODE_H_FPORCH,
                                            MODE_H_SYNC, MODE_H_BPORCH);
   localparam int MODE_V_TOTAL = axis_total(MODE_V_VISIBLE, MODE_V_FPORCH,
                                            MODE_V_SYNC, MODE_V_BPORCH);

endpackage

// File: rtl/vga_mod_counter.sv
// Generic modulo-N counter with enable. wrap flags the terminal count (N-1);
// count_nxt exposes the value the register takes on the next edge.
module vga_mod_counter
   import vga_timing_pkg::*;
#(
   parameter int N  = 16,
   parameter int CW = MODE_CW
) (
   input  logic          pclk,
   input  logic          rst_n,
   input  logic          ce,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_nxt,
   output logic          wrap
);

   assign wrap = (count == CW'(N - 1));

   always_comb begin
      count_nxt = count;
      if (ce) count_nxt = wrap ? '0 : count + CW'(1);
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) count <= '0;
      else        count <= count_nxt;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters, sync pulses, blanking flags and frame
// markers, all registered and aligned to the counts shown on the same cycle.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = MODE_H_VISIBLE,
   parameter int H_FPORCH  = MODE_H_FPORCH,
   parameter int H_SYNC    = MODE_H_SYNC,
   parameter int H_BPORCH  = MODE_H_BPORCH,
   parameter int V_VISIBLE = MODE_V_VISIBLE,
   parameter int V_FPORCH  = MODE_V_FPORCH,
   parameter int V_SYNC    = MODE_V_SYNC,
   parameter int V_BPORCH  = MODE_V_BPORCH,
   parameter bit SYNC_POL  = MODE_SYNC_POL,
   parameter int CW        = MODE_CW
) (
   input  logic          pclk,
   input  logic          rst_n,
   input  logic          ce,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          hsync,
   output logic          vsync,
   output logic          hblnk,
   output logic          vblnk,
   output logic          frame_start,
   output logic [15:0]   frame_cnt
);

   localparam int H_TOTAL  = axis_total(H_VISIBLE, H_FPORCH, H_SYNC, H_BPORCH);
   localparam int V_TOTAL  = axis_total(V_VISIBLE, V_FPORCH, V_SYNC, V_BPORCH);
   localparam int HS_START = H_VISIBLE + H_FPORCH;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FPORCH;
   localparam int VS_END   = VS_START + V_SYNC;

   logic [CW-1:0] h_nxt, v_nxt;
   logic          h_wrap, v_wrap, v_ce, frame_wrap;
   logic          hs_act, vs_act;

   assign v_ce       = ce & h_wrap;
   assign frame_wrap = v_ce & v_wrap;

   vga_mod_counter #(.N(H_TOTAL), .CW(CW)) u_hcnt (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .ce        (ce),
      .count     (hcount),
      .count_nxt (h_nxt),
      .wrap      (h_wrap)
   );

   vga_mod_counter #(.N(V_TOTAL), .CW(CW)) u_vcnt (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .ce        (v_ce),
      .count     (vcount),
      .count_nxt (v_nxt),
      .wrap      (v_wrap)
   );

   // Decode from next-state counts so the registered flags line up with hcount/vcount.
   assign hs_act = (h_nxt >= CW'(HS_START)) && (h_nxt < CW'(HS_END));
   assign vs_act = (v_nxt >= CW'(VS_START)) && (v_nxt < CW'(VS_END));

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= !SYNC_POL;
         vsync       <= !SYNC_POL;
         hblnk       <= 1'b0;
         vblnk       <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else if (ce) begin
         hsync       <= hs_act ? SYNC_POL : !SYNC_POL;
         vsync       <= vs_act ? SYNC_POL : !SYNC_POL;
         hblnk       <= (h_nxt >= CW'(H_VISIBLE));
         vblnk       <= (v_nxt >= CW'(V_VISIBLE));
         frame_start <= frame_wrap;
         if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
      end else begin
         frame_start <= 1'b0;
      end
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Pixel-timing generator for the VGA path. It produces the horizontal and vertical counters, sync pulses and blanking flags for 800x600 at 60 Hz (40 MHz pixel rate, 1056x628 total raster). The drawing stage and the frame capture bench consume these outputs. It sits directly upstream of the pixel/drawing logic that drives hs, vs, r, g and b at the top level.

Parameters:
H_VISIBLE, 800, active pixels per line
H_FPORCH, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_BPORCH, 88, horizontal back porch (pixels); H_TOTAL = sum = 1056
V_VISIBLE, 600, active lines per frame
V_FPORCH, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BPORCH, 23, vertical back porch (lines); V_TOTAL = sum = 628
SYNC_POL, 1, 1 = sync pulses active-high, 0 = active-low
CW, 11, counter width; must satisfy 2^CW > max(H_TOTAL, V_TOTAL)

Ports:
pclk  in  1  pixel clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  pixel enable; counters advance only when 1
hcount  out  CW  current pixel column, 0..H_TOTAL-1
vcount  out  CW  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity per SYNC_POL
vsync  out  1  vertical sync, polarity per SYNC_POL
hblnk  out  1  1 when hcount >= H_VISIBLE
vblnk  out  1  1 when vcount >= V_VISIBLE
frame_start  out  1  one-cycle pulse when counters move to (0,0)
frame_cnt  out  16  frames completed since reset, wraps at 65535->0

Behaviour:
- Reset is asynchronous on rst_n low and takes effect immediately. During reset: hcount=0, vcount=0, hblnk=0, vblnk=0, frame_cnt=0, frame_start=0, hsync=vsync=inactive level (0 if SYNC_POL=1, 1 otherwise).
- Release is synchronous. The first ce=1 edge after release moves hcount to 1.
- All outputs are registered, with no combinational path from input to output. Flags are computed from the next-state counts, so on any cycle the flags match the hcount/vcount shown on that cycle (zero skew).
- Horizontal counting: when ce=1, hcount increments. At H_TOTAL-1 it wraps to 0.
- Vertical counting: vcount increments only on the cycle where hcount wraps. At V_TOTAL-1 it wraps to 0 at the same time as the hcount wrap.
- ce=0: all registers hold, including the flags. frame_start is forced to 0 on any cycle where ce=0.
- hsync is active for H_VISIBLE+H_FPORCH <= hcount < H_VISIBLE+H_FPORCH+H_SYNC, i.e. 840..967.
- vsync is active for V_VISIBLE+V_FPORCH <= vcount < V_VISIBLE+V_FPORCH+V_SYNC, i.e. 601..604, over the full width of those lines.
- hblnk covers hcount 800..1055. vblnk covers vcount 600..627.
- frame_start is 1 for exactly one ce-qualified cycle, the one on which (hcount,vcount) becomes (0,0) after a full-frame wrap. No pulse is produced on reset release.
- frame_cnt increments on that same cycle, modulo 2^16.
- Reset asserted mid-frame: outputs return to reset values immediately. The next frame starts at (0,0) and frame_cnt=0.
- Frame period with ce tied high: 663168 pclk cycles.

Decomposition:
- Package vga_timing_pkg holds the mode constants (the 800x600@60 parameter set above) and a derived function for H_TOTAL/V_TOTAL. The top level and the drawing stages share these constants.
- One sub-module: vga_mod_counter. It is a generic modulo-N counter with ce, wrap output and async active-low reset, instantiated once for the horizontal axis and once for the vertical axis. The vertical instance's ce is the horizontal instance's wrap ANDed with ce.

Test Plan:
- Reset: hold rst_n=0 for 10 cycles, then release with ce=1 -> during reset all outputs are at reset values. After release, hcount reads 0,1,2 on the next edges and vcount=0.
- Horizontal timing: ce=1 for one line -> hsync goes active exactly when hcount=840 and inactive when hcount=968. hblnk rises at hcount=800. hcount goes 1055->0 and vcount goes 0->1 on the same edge.
- Vertical timing: run a full frame -> vsync is active from (0,601) to (1055,604), a span of 4224 cycles. vblnk rises at (0,600). frame_start pulses once after 663168 cycles and frame_cnt reads 1.
- Clock enable: ce toggled 1,0 alternately (20 MHz effective) -> counts hold on ce=0 cycles, the frame period doubles to 1326336 pclk cycles, and frame_start is never 1 on a ce=0 cycle.
- Mid-frame reset: pulse rst_n low at (500,300) with frame_cnt=3 -> outputs clear asynchronously and the counts restart at 0 with frame_cnt=0. No frame_start fires on release.
- Polarity: rebuild with SYNC_POL=0 -> hsync and vsync idle at 1 and go to 0 over the same 840..967 and 601..604 windows.
